// File: rtl/reg_enable_seq.sv
// Registered, handshaked one-hot register write-enable sequencer (pulse, then optional gap).
// Optional write-lock mask enabled by defining REG_ENABLE_SEQ_LOCK_EN.
module reg_enable_seq #(
  parameter int NUM_REGS  = 8,
  parameter int SEL_W     = 3,
  parameter int PULSE_CYC = 1,
  parameter int GAP_CYC   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [SEL_W-1:0]    reg_num,
`ifdef REG_ENABLE_SEQ_LOCK_EN
  input  logic                lock_wr,
  input  logic [NUM_REGS-1:0] lock_mask,
`endif
  output logic                req_ready,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic                done,
  output logic                err
);

  localparam int MAXC  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [SEL_W:0]   NR       = (SEL_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REGS-1:0] en_q, en_d;
  logic                err_q, err_d;
  logic                in_range;
  logic                locked;
  logic [NUM_REGS-1:0] sel_oh;

  // Index 0 maps to the MSB.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] k);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (k == SEL_W'(i)) oh[NUM_REGS-1-i] = 1'b1;
    end
    return oh;
  endfunction

  assign sel_oh   = onehot(reg_num);
  assign in_range = ({1'b0, reg_num} < NR);

`ifdef REG_ENABLE_SEQ_LOCK_EN
  logic [NUM_REGS-1:0] lock_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lock_q <= '0;
    else if (lock_wr) lock_q <= lock_mask;
  end

  // Same-edge lock writes take effect only for later requests.
  assign locked = |(sel_oh & lock_q);
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        en_d = '0;
        if (req_valid) begin
          if (in_range && !locked) begin
            state_d = PULSE;
            en_d    = sel_oh;
            cnt_d   = PULSE_LD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          en_d = '0;
          if (GAP_CYC > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        en_d = '0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        en_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign reg_enable = en_q;
  assign done       = (state_q == PULSE) && (cnt_q == '0);
  assign err        = err_q;

endmodule
